// File: rtl/audio_tone_detector_if.sv
// Audio-in pop handshake plus tone measurement results for audio_tone_detector.
// master = Audio_Controller / consumer side, slave = the detector itself.
interface audio_tone_detector_if;
    logic               audio_in_available;
    logic signed [31:0] left_channel_audio_in;
    logic               read_audio_in;
    logic [19:0]        period_out;
    logic               period_valid;
    logic [3:0]         tone_code;
    logic               tone_present;

    modport master (
        output audio_in_available, left_channel_audio_in,
        input  read_audio_in, period_out, period_valid, tone_code, tone_present
    );

    modport slave (
        input  audio_in_available, left_channel_audio_in,
        output read_audio_in, period_out, period_valid, tone_code, tone_present
    );
endinterface

// File: rtl/audio_tone_detector.sv
// Pops left-channel audio samples, finds hysteresis zero crossings, measures the tone period
// and decodes the tone generator switch code. Define AUDIO_TONE_DETECT_AVG_EN for 4-period averaging.
module audio_tone_detector #(
    parameter logic signed [31:0] THRESH     = 32'sd50000000,
    parameter logic [19:0]        MIN_PERIOD = 20'd2000,
    parameter logic [19:0]        TIMEOUT    = 20'd1000000
) (
    input logic                   CLOCK_50,
    input logic                   reset,
    audio_tone_detector_if.slave  bus
);

    localparam logic signed [31:0] NEG_THRESH = -THRESH;

    typedef enum logic [1:0] {SEARCH, HIGH, LOW} state_t;

    state_t             state;
    logic               read_q;
    logic               smp_vld;
    logic signed [31:0] smp;
    logic               first_edge;
    logic [19:0]        elapsed;
    logic [19:0]        period_q;
    logic [3:0]         code_q;
    logic               valid_q;
    logic               present_q;

    logic               is_high;
    logic               is_low;
    logic               rise;
    logic               arm;
    logic               accept;
    logic               timeout;
    logic [19:0]        rpt_period;
    logic               rpt_ok;

    // Round half period to the nearest multiple of 2^15, clamped to the 4-bit switch range.
    function automatic logic [3:0] decode(input logic [19:0] p);
        logic [19:0] r;
        r = {1'b0, p[19:1]} + 20'd16384;
        decode = (r[19:15] > 5'd15) ? 4'd15 : r[18:15];
    endfunction

    assign is_high = smp_vld && (smp >= THRESH);
    assign is_low  = smp_vld && (smp <= NEG_THRESH);
    assign rise    = (state == LOW) && is_high;
    assign arm     = rise && !first_edge;
    assign accept  = rise && first_edge && (elapsed >= MIN_PERIOD);
    // An edge accepted on the timeout cycle takes priority over losing the tone.
    assign timeout = first_edge && (elapsed == TIMEOUT) && !accept;

`ifdef AUDIO_TONE_DETECT_AVG_EN
    logic [19:0] hist [4];
    logic [21:0] sum;
    logic [21:0] sum_nxt;
    logic [2:0]  fill;

    // Empty history slots hold zero, so the oldest slot can always be subtracted.
    assign sum_nxt    = sum + {2'b00, elapsed} - {2'b00, hist[3]};
    assign rpt_period = sum_nxt[21:2];
    assign rpt_ok     = (fill >= 3'd3);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            hist <= '{default: '0};
            sum  <= '0;
            fill <= '0;
        end else if (timeout) begin
            hist <= '{default: '0};
            sum  <= '0;
            fill <= '0;
        end else if (accept) begin
            hist[0] <= elapsed;
            hist[1] <= hist[0];
            hist[2] <= hist[1];
            hist[3] <= hist[2];
            sum     <= sum_nxt;
            if (fill != 3'd4) fill <= fill + 3'd1;
        end
    end
`else
    assign rpt_period = elapsed;
    assign rpt_ok     = 1'b1;
`endif

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= SEARCH;
            read_q     <= 1'b0;
            smp_vld    <= 1'b0;
            smp        <= '0;
            first_edge <= 1'b0;
            elapsed    <= '0;
            period_q   <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            present_q  <= 1'b0;
        end else begin
            read_q  <= bus.audio_in_available && !read_q;
            smp_vld <= read_q;
            if (read_q) smp <= bus.left_channel_audio_in;

            valid_q <= 1'b0;

            if (arm || accept)
                elapsed <= 20'd1;
            else if (elapsed < TIMEOUT)
                elapsed <= elapsed + 20'd1;

            if (arm) first_edge <= 1'b1;

            if (accept) begin
                present_q <= 1'b1;
                if (rpt_ok) begin
                    period_q <= rpt_period;
                    code_q   <= decode(rpt_period);
                    valid_q  <= 1'b1;
                end
            end

            if (timeout) begin
                state      <= SEARCH;
                first_edge <= 1'b0;
                present_q  <= 1'b0;
            end else begin
                case (state)
                    SEARCH:  if (is_high) state <= HIGH;
                             else if (is_low) state <= LOW;
                    HIGH:    if (is_low) state <= LOW;
                    LOW:     if (is_high) state <= HIGH;
                    default: state <= SEARCH;
                endcase
            end
        end
    end

    assign bus.read_audio_in = read_q;
    assign bus.period_out    = period_q;
    assign bus.period_valid  = valid_q;
    assign bus.tone_code     = code_q;
    assign bus.tone_present  = present_q;

endmodule

// File: tb/tb_audio_tone_detector.sv
// Self-checking bench for audio_tone_detector: handshake table, directed tone sequences,
// and randomized sample streams checked against an edge-timestamp reference model.
module tb_audio_tone_detector;

    localparam logic signed [31:0] TH   = 32'sd50000000;
    localparam logic [19:0]        MINP = 20'd100;
    localparam logic [19:0]        TOUT = 20'd33000;
    localparam int THI = 50000000;
    localparam int BIG = 100000000;
    localparam int SUB = 40000000;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;

    always #10 CLOCK_50 = ~CLOCK_50;

    audio_tone_detector_if bus ();

    audio_tone_detector #(
        .THRESH     (TH),
        .MIN_PERIOD (MINP),
        .TIMEOUT    (TOUT)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    typedef struct {
        int t;
        int s;
    } pend_t;

    typedef struct {
        bit av;
        bit exp_rd;
    } hs_vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_cnt = 0;

    // Reference model: pops are timestamped, crossings become edge times, periods are differences.
    bit    m_read;
    pend_t pq[$];
    int    m_level;
    bit    m_armed;
    int    m_last;
    int    m_period;
    int    m_code;
    bit    m_valid;
    bit    m_present;
    int    hist[$];

    function automatic int code_of(input int p);
        int c;
        c = ((p / 2) + 16384) / 32768;
        return (c > 15) ? 15 : c;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_read = 0;
        pq.delete();
        m_level = 0;
        m_armed = 0;
        m_last = 0;
        m_period = 0;
        m_code = 0;
        m_valid = 0;
        m_present = 0;
        hist.delete();
    endtask

    task automatic report(input int d);
`ifdef AUDIO_TONE_DETECT_AVG_EN
        int sum;
        hist.push_back(d);
        if (hist.size() > 4) void'(hist.pop_front());
        if (hist.size() == 4) begin
            sum = hist[0] + hist[1] + hist[2] + hist[3];
            m_period = sum / 4;
            m_code = code_of(m_period);
            m_valid = 1;
        end
`else
        m_period = d;
        m_code = code_of(d);
        m_valid = 1;
`endif
    endtask

    task automatic model_edge();
        pend_t p;
        bit rise;
        bit acc;
        rise = 0;
        acc = 0;
        m_valid = 0;
        if (pq.size() > 0 && pq[0].t == cyc) begin
            p = pq.pop_front();
            if (p.s >= THI) begin
                rise = (m_level == -1);
                m_level = 1;
            end else if (p.s <= -THI) begin
                m_level = -1;
            end
        end
        if (rise) begin
            if (!m_armed) begin
                m_armed = 1;
                m_last = cyc;
            end else if (cyc - m_last >= int'(MINP)) begin
                acc = 1;
                report(cyc - m_last);
                m_last = cyc;
                m_present = 1;
            end
        end
        if (m_armed && !acc && (cyc - m_last) == int'(TOUT)) begin
            m_armed = 0;
            m_present = 0;
            m_level = 0;
            hist.delete();
        end
    endtask

    task automatic check_outputs();
        chk("read_audio_in", int'(bus.read_audio_in), int'(m_read));
        chk("period_valid", int'(bus.period_valid), int'(m_valid));
        chk("period_out", int'(bus.period_out), m_period);
        chk("tone_code", int'(bus.tone_code), m_code);
        chk("tone_present", int'(bus.tone_present), int'(m_present));
    endtask

    // Drive one cycle of inputs (called at a negedge), advance the model at the posedge, compare at the next negedge.
    task automatic tick(input bit av, input int s);
        bit nxt;
        bus.audio_in_available = av;
        bus.left_channel_audio_in = s;
        if (m_read) pq.push_back('{cyc + 2, s});
        nxt = av && !m_read;
        @(posedge CLOCK_50);
        cyc++;
        m_read = nxt;
        model_edge();
        @(negedge CLOCK_50);
        if (bus.period_valid) valid_cnt++;
        check_outputs();
    endtask

    task automatic level(input int v, input int n);
        for (int k = 0; k < n; k++) tick(1'b1, v);
    endtask

    task automatic pulse_reset();
        bus.audio_in_available = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk("rst_read", int'(bus.read_audio_in), 0);
        chk("rst_valid", int'(bus.period_valid), 0);
        chk("rst_period", int'(bus.period_out), 0);
        chk("rst_code", int'(bus.tone_code), 0);
        chk("rst_present", int'(bus.tone_present), 0);
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        hs_vec_t hs_tab[24];
        int pulses;
        int vc0;
        int acc_edge;
        int fall_cyc;

        for (int i = 0; i < 24; i++) begin
            hs_tab[i].av = (i >= 2 && i < 22);
            hs_tab[i].exp_rd = (i >= 2 && i <= 20 && (i % 2) == 0);
        end

        bus.audio_in_available = 1'b0;
        bus.left_channel_audio_in = 0;
        model_reset();
        @(negedge CLOCK_50);
        chk("init_read", int'(bus.read_audio_in), 0);
        chk("init_valid", int'(bus.period_valid), 0);
        chk("init_period", int'(bus.period_out), 0);
        chk("init_code", int'(bus.tone_code), 0);
        chk("init_present", int'(bus.tone_present), 0);
        @(negedge CLOCK_50);
        reset = 1'b0;

        // Handshake: 20 cycles of availability give 10 isolated pops.
        pulses = 0;
        for (int i = 0; i < 24; i++) begin
            tick(hs_tab[i].av, 0);
            chk("hs_read_tab", int'(bus.read_audio_in), int'(hs_tab[i].exp_rd));
            if (bus.read_audio_in) pulses++;
        end
        chk("hs_pulse_count", pulses, 10);
        for (int i = 0; i < 6; i++) tick(1'b0, BIG);

        // Sub-threshold square wave never locks.
        vc0 = valid_cnt;
        for (int i = 0; i < 4; i++) begin
            level(SUB, 150);
            level(-SUB, 150);
        end
        chk("sub_valid_count", valid_cnt - vc0, 0);
        chk("sub_present", int'(bus.tone_present), 0);

        // Long tone decoding to switch code 1, then silence until the tone is lost.
        level(-BIG, 10);
        level(BIG, 16400);
        level(-BIG, 16400);
        level(BIG, 10);
        acc_edge = m_last;
        chk("lock_present", int'(bus.tone_present), 1);
`ifndef AUDIO_TONE_DETECT_AVG_EN
        chk("lock_period", int'(bus.period_out), 32800);
        chk("lock_code", int'(bus.tone_code), 1);
`endif
        fall_cyc = -1;
        for (int i = 0; i < int'(TOUT) + 100; i++) begin
            tick(1'b1, 0);
            if (!bus.tone_present) begin
                fall_cyc = cyc;
                break;
            end
        end
        chk("timeout_delay", fall_cyc - acc_edge, int'(TOUT));
        chk("timeout_present", int'(bus.tone_present), 0);
`ifndef AUDIO_TONE_DETECT_AVG_EN
        chk("timeout_hold_period", int'(bus.period_out), 32800);
        chk("timeout_hold_code", int'(bus.tone_code), 1);
`endif

        // Glitch 30 cycles after an accepted edge is ignored; next true edge measures from the accepted one.
        vc0 = valid_cnt;
        level(-BIG, 10);
        level(BIG, 200);
        level(-BIG, 200);
        level(BIG, 20);
        level(-BIG, 10);
        level(BIG, 30);
        level(-BIG, 340);
        level(BIG, 10);
`ifndef AUDIO_TONE_DETECT_AVG_EN
        chk("glitch_period", int'(bus.period_out), 400);
        chk("glitch_valid_count", valid_cnt - vc0, 2);
`else
        chk("glitch_valid_count", valid_cnt - vc0, 0);
`endif

        // Reset in the middle of a period, then two fresh rising edges.
        level(-BIG, 100);
        pulse_reset();
        vc0 = valid_cnt;
        level(-BIG, 10);
        level(BIG, 200);
        level(-BIG, 200);
        level(BIG, 10);
`ifndef AUDIO_TONE_DETECT_AVG_EN
        chk("reset_valid_count", valid_cnt - vc0, 1);
`else
        chk("reset_valid_count", valid_cnt - vc0, 0);
`endif

        // MIN_PERIOD boundary: 98 ignored, 198 and exactly 100 accepted.
        pulse_reset();
        vc0 = valid_cnt;
        level(-BIG, 10);
        level(BIG, 50);
        level(-BIG, 48);
        level(BIG, 50);
        level(-BIG, 50);
        level(BIG, 50);
        level(-BIG, 50);
        level(BIG, 10);
`ifndef AUDIO_TONE_DETECT_AVG_EN
        chk("minp_period", int'(bus.period_out), 100);
        chk("minp_valid_count", valid_cnt - vc0, 2);
`endif

        // Random segments with irregular availability.
        pulse_reset();
        for (int seg = 0; seg < 60; seg++) begin
            int kind;
            int len;
            int v;
            kind = int'($urandom_range(0, 6));
            len = int'($urandom_range(4, 120));
            case (kind)
                0: v = BIG;
                1: v = -BIG;
                2: v = SUB;
                3: v = -SUB;
                4: v = THI;
                5: v = -THI;
                default: v = int'($urandom);
            endcase
            for (int k = 0; k < len; k++) tick($urandom_range(0, 9) != 0, v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
